// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: latches one request, runs a req/ack handshake with data
// memory (with timeout), and returns lane-aligned, extended load data to MEM/WB.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_we,
  output logic        err_misaligned,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_we_q, resp_we_d;
  logic        err_mis_q, err_mis_d;
  logic        err_ill_q, err_ill_d;
  logic        err_to_q, err_to_d;

  logic        is_illegal, is_misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  // Illegal takes precedence; odd funct3 codes have no alignment meaning.
  assign is_illegal    = req_write ? (req_funct3 > 3'b010)
                                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign is_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    st_wdata = req_wdata;
    st_strb  = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_strb  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_strb  = 4'b1111;
      end
    endcase
  end

  assign ld_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'd0, ld_shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wr_d         = wr_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'd0;
    resp_rd_d    = 5'd0;
    resp_we_d    = 1'b0;
    err_mis_d    = 1'b0;
    err_ill_d    = 1'b0;
    err_to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d        = req_write;
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          rd_d        = req_rd;
          wait_d      = 8'd0;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = st_wdata;
          if (is_illegal || is_misaligned) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_rd_d    = req_write ? 5'd0 : req_rd;
            err_ill_d    = is_illegal;
            err_mis_d    = !is_illegal;
          end else begin
            state_d     = REQ;
            mem_we_d    = req_write;
            mem_wstrb_d = req_write ? st_strb : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_ack || wait_q == LAST_WAIT) begin
          state_d      = DONE;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = 4'b0000;
          resp_valid_d = 1'b1;
          resp_rd_d    = wr_q ? 5'd0 : rd_q;
          if (mem_ack) begin
            resp_data_d = wr_q ? 32'd0 : ld_data;
            resp_we_d   = !wr_q;
          end else begin
            err_to_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= 8'd0;
      wr_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_rd_q    <= 5'd0;
      resp_we_q    <= 1'b0;
      err_mis_q    <= 1'b0;
      err_ill_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wr_q         <= wr_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_we_q    <= resp_we_d;
      err_mis_q    <= err_mis_d;
      err_ill_q    <= err_ill_d;
      err_to_q     <= err_to_d;
    end
  end

  // mem_req follows state directly so an asynchronous reset drops it at once.
  assign mem_req        = (state_q == REQ);
  assign req_ready      = (state_q == IDLE);
  assign stall          = (state_q == REQ) || (state_q == IDLE && req_valid);
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wstrb      = mem_wstrb_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_rd        = resp_rd_q;
  assign resp_we        = resp_we_q;
  assign err_misaligned = err_mis_q;
  assign err_illegal    = err_ill_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand-written timeout and reset-during-access sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        err_misaligned;
  logic        err_illegal;
  logic        err_timeout;
  logic        stall;

  load_store_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_we(resp_we),
    .err_misaligned(err_misaligned), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;      // REQ cycles up to and including the ack cycle
    logic [4:0]  rd;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_mis;
    logic        e_ill;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k, input logic [4:0] rd,
                              input logic [31:0] ew, input logic [3:0] es,
                              input logic [31:0] ed, input logic ewe,
                              input logic emis, input logic eill);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.k = k;
    v.rd = rd; v.e_wdata = ew; v.e_strb = es; v.e_data = ed; v.e_we = ewe;
    v.e_mis = emis; v.e_ill = eill;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    int          req_cyc;
    int          stall_cyc;
    int          lat;
    logic        got;
    logic        stable;
    logic        access;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  s0;
    logic        we0;
    string       p;
    p = $sformatf("v%0d", i);
    access = !(v.e_mis || v.e_ill);
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    #1;
    chk({p, " req_ready"}, 32'(req_ready), 32'd1);
    chk({p, " stall_accept"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    // scramble request inputs to prove they were latched
    req_valid = 1'b0; req_write = ~v.wr; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_rd = 5'd0;
    req_cyc = 0; stall_cyc = 1; lat = 0; got = 1'b0; stable = 1'b1;
    a0 = '0; w0 = '0; s0 = '0; we0 = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      if (resp_valid) begin
        got = 1'b1;
        chk({p, " resp_data"}, resp_data, v.e_data);
        chk({p, " resp_we"}, 32'(resp_we), 32'(v.e_we));
        chk({p, " resp_rd"}, 32'(resp_rd), v.wr ? 32'd0 : 32'(v.rd));
        chk({p, " err_misaligned"}, 32'(err_misaligned), 32'(v.e_mis));
        chk({p, " err_illegal"}, 32'(err_illegal), 32'(v.e_ill));
        chk({p, " err_timeout"}, 32'(err_timeout), 32'd0);
        chk({p, " stall_resp"}, 32'(stall), 32'd0);
        chk({p, " mem_req_resp"}, 32'(mem_req), 32'd0);
      end else begin
        if (stall) stall_cyc++;
        if (mem_req) begin
          req_cyc++;
          if (req_cyc == 1) begin
            a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we;
            chk({p, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
            chk({p, " mem_we"}, 32'(mem_we), 32'(v.wr));
            chk({p, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_strb));
            if (v.wr) chk({p, " mem_wdata"}, mem_wdata, v.e_wdata);
          end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_wstrb !== s0 || mem_we !== we0) begin
            stable = 1'b0;
          end
          if (req_cyc == v.k) begin
            mem_ack = 1'b1;
            mem_rdata = v.rdata;
          end else begin
            mem_rdata = ~v.rdata;
          end
        end
      end
    end
    chk({p, " resp_seen"}, 32'(got), 32'd1);
    chk({p, " latency"}, 32'(lat), access ? 32'(v.k + 1) : 32'd1);
    chk({p, " req_cycles"}, 32'(req_cyc), access ? 32'(v.k) : 32'd0);
    chk({p, " stall_cycles"}, 32'(stall_cyc), access ? 32'(v.k + 1) : 32'd1);
    chk({p, " mem_stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk({p, " resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({p, " ready_after"}, 32'(req_ready), 32'd1);
    $display("txn %0d: wr=%0b f3=%0d addr=0x%08h lat=%0d resp_data=0x%08h", i, v.wr, v.f3, v.addr, lat, resp_data);
  endtask

  initial begin
    int   req_cyc;
    int   lat;
    logic got;
    logic saw_resp;

    vecs[0]  = mk(1'b0, 3'b010, 32'h104, 32'h0, 32'h8000_00FF, 3, 5'd1, 32'h0, 4'b0000, 32'h8000_00FF, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0, 32'h9A00_0000, 1, 5'd2, 32'h0, 4'b0000, 32'hFFFF_FF9A, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0, 32'h9A00_0000, 2, 5'd3, 32'h0, 4'b0000, 32'h0000_009A, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 5'd4, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 2, 5'd5, 32'h0, 4'b0000, 32'h0000_8001, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 3'b001, 32'h100, 32'h0, 32'h1234_7FFE, 1, 5'd6, 32'h0, 4'b0000, 32'h0000_7FFE, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 3'b000, 32'h202, 32'h1234_56AB, 32'h0, 2, 5'd7, 32'hABAB_ABAB, 4'b0100, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 3'b001, 32'h202, 32'h1234_56AB, 32'h0, 1, 5'd8, 32'h56AB_56AB, 4'b1100, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 3'b010, 32'h200, 32'hCAFE_BABE, 32'h0, 4, 5'd9, 32'hCAFE_BABE, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 3'b000, 32'h201, 32'h0000_0077, 32'h0, 1, 5'd10, 32'h7777_7777, 4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 5'd11, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 5'd12, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 3'b011, 32'h200, 32'h11, 32'h0, 0, 5'd13, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 3'b110, 32'h200, 32'h0, 32'h0, 0, 5'd14, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 3'b001, 32'h203, 32'h55, 32'h0, 0, 5'd15, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 3'b010, 32'h10C, 32'h0, 32'h0123_4567, 1, 5'd31, 32'h0, 4'b0000, 32'h0123_4567, 1'b1, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFF_FF45, 1, 5'd16, 32'h0, 4'b0000, 32'h0000_0045, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_C300, 3, 5'd17, 32'h0, 4'b0000, 32'h0000_00C3, 1'b1, 1'b0, 1'b0);

    // reset state
    #1 reset = 1'b1;
    #2;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst resp_rd", 32'(resp_rd), 32'd0);
    chk("rst resp_we", 32'(resp_we), 32'd0);
    chk("rst errs", {29'd0, err_misaligned, err_illegal, err_timeout}, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // timeout: ack never arrives, then a late ack must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_cyc = 0; lat = 0; got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
        chk("to err_timeout", 32'(err_timeout), 32'd1);
        chk("to resp_we", 32'(resp_we), 32'd0);
        chk("to resp_data", resp_data, 32'd0);
        chk("to other_errs", {30'd0, err_misaligned, err_illegal}, 32'd0);
        chk("to mem_req_resp", 32'(mem_req), 32'd0);
      end else if (mem_req) begin
        req_cyc++;
      end
    end
    chk("to resp_seen", 32'(got), 32'd1);
    chk("to req_cycles", 32'(req_cyc), 32'd4);
    @(negedge clk);
    chk("to ready_after", 32'(req_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("to late_ack_resp", 32'(resp_valid), 32'd0);
    chk("to late_ack_req", 32'(mem_req), 32'd0);
    $display("txn timeout: mem_req cycles=%0d", req_cyc);

    // reset asserted while REQ is outstanding
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rr mem_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rr mem_req_async", 32'(mem_req), 32'd0);
    chk("rr req_ready", 32'(req_ready), 32'd1);
    chk("rr stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || mem_req) saw_resp = 1'b1;
    end
    chk("rr no_resp", 32'(saw_resp), 32'd0);
    $display("txn reset-mid-access: abandoned");
    run_vec(100, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
